// File: rtl/alu_pkg.sv
// alu_pkg: operation, shift-fill and FSM state encodings shared by alu_seq and its bench.
// fill_bit resolves the bit shifted in on one shift step.
package alu_pkg;

    typedef enum logic [3:0] {
        XORR = 4'd0,
        AND  = 4'd1,
        SHL  = 4'd2,
        SHR  = 4'd3,
        INC  = 4'd4,
        DEC  = 4'd5,
        HALF = 4'd6,
        CMP  = 4'd7,
        MUL  = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        FILL_ZERO  = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_CARRY = 2'd2,
        FILL_RSVD  = 2'd3
    } fill_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // The reserved fill code behaves like zero fill.
    function automatic logic fill_bit(input logic [1:0] fill, input logic live_carry);
        case (fill)
            FILL_ONE:   return 1'b1;
            FILL_CARRY: return live_carry;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add multiplier, one partial product per cycle over W cycles.
// prod/done are combinational so the caller can capture the final step on the same edge.
module alu_seq_mul #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] prod
);
    localparam int CW = $clog2(W);

    logic [W-1:0]   a_q;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_nxt;
    logic [W:0]     sum;
    logic [CW-1:0]  cnt;
    logic           busy;

    // acc holds {partial high half, remaining multiplier bits}; each step adds and shifts right.
    always_comb begin
        sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_q} : {(W+1){1'b0}});
        acc_nxt = {sum, acc[W-1:1]};
    end

    assign done = busy && (cnt == CW'(W-1));
    assign prod = acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            a_q  <= a;
            acc  <= {{W{1'b0}}, b};
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready on both sides and persistent carry/ne/lt flags.
// Shifts step one bit per cycle through the carry; MUL runs in alu_seq_mul.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W   = 8,
    parameter int SHW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     op,
    input  logic [1:0]     fill,
    input  logic [SHW-1:0] amt,
    input  logic [W-1:0]   inA,
    input  logic [W-1:0]   inB,
    input  logic [W/2-1:0] immed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   rslt,
    output logic           carry,
    output logic           notequal,
    output logic           lessthan,
    output logic           illegal
);
    state_e         state;
    state_e         state_nxt;
    logic           accept;
    logic           start_shift;
    logic           start_mul;
    logic           busy_last;

    logic [3:0]     op_q;
    logic [1:0]     fill_q;
    logic [W-1:0]   sh_r;
    logic           sh_c;
    logic [SHW-1:0] sh_cnt;
    logic [W-1:0]   step_r;
    logic           step_c;
    logic           step_f;

    logic [W-1:0]   imm_rslt;
    logic           imm_carry;
    logic           imm_ill;
    logic           imm_cmp;

    logic           mul_done;
    logic [2*W-1:0] mul_prod;

    assign in_ready    = rst_n && (state == IDLE);
    assign out_valid   = (state == DONE);
    assign accept      = in_valid && in_ready;
    assign start_shift = ((op == SHL) || (op == SHR)) && (amt != '0);
    assign start_mul   = (op == MUL);
    assign busy_last   = (op_q == MUL) ? mul_done : (sh_cnt == SHW'(1));

    alu_seq_mul #(.W(W)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && start_mul),
        .a     (inA),
        .b     (inB),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Only shifts with a nonzero amount and MUL pass through BUSY.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (start_shift || start_mul) ? BUSY : DONE;
            BUSY: if (busy_last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One shift step; the fill bit sees the working carry, so fill=2 rotates through it.
    always_comb begin
        step_f = fill_bit(fill_q, sh_c);
        step_r = sh_r;
        step_c = sh_c;
        if (op_q == SHL) begin
            {step_c, step_r} = {sh_r, step_f};
        end else begin
            {step_r, step_c} = {step_f, sh_r};
        end
    end

    always_comb begin
        imm_rslt  = '0;
        imm_carry = carry;
        imm_ill   = 1'b0;
        imm_cmp   = 1'b0;
        case (op)
            XORR:     imm_rslt = W'(^inA);
            AND:      imm_rslt = inA & inB;
            SHL, SHR: imm_rslt = inA;
            INC:      {imm_carry, imm_rslt} = {1'b0, inA} + (W+1)'(1);
            DEC: begin
                imm_rslt  = inA - W'(1);
                imm_carry = (inA == '0);
            end
            HALF:     imm_rslt = {inA[W/2-1:0], immed};
            CMP:      imm_cmp = 1'b1;
            MUL:      imm_rslt = '0;
            default:  imm_ill = 1'b1;
        endcase
    end

    // Result and flags are written only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rslt     <= '0;
            carry    <= 1'b0;
            notequal <= 1'b0;
            lessthan <= 1'b0;
            illegal  <= 1'b0;
            op_q     <= '0;
            fill_q   <= '0;
            sh_r     <= '0;
            sh_c     <= 1'b0;
            sh_cnt   <= '0;
        end else if (accept) begin
            op_q   <= op;
            fill_q <= fill;
            sh_r   <= inA;
            sh_c   <= carry;
            sh_cnt <= amt;
            if (!(start_shift || start_mul)) begin
                rslt    <= imm_rslt;
                carry   <= imm_carry;
                illegal <= imm_ill;
                if (imm_cmp) begin
                    notequal <= (inA != inB);
                    lessthan <= (inA < inB);
                end
            end
        end else if (state == BUSY) begin
            if (op_q == MUL) begin
                if (mul_done) begin
                    rslt    <= mul_prod[W-1:0];
                    carry   <= |mul_prod[2*W-1:W];
                    illegal <= 1'b0;
                end
            end else begin
                sh_r   <= step_r;
                sh_c   <= step_c;
                sh_cnt <= sh_cnt - SHW'(1);
                if (busy_last) begin
                    rslt    <= step_r;
                    carry   <= step_c;
                    illegal <= 1'b0;
                end
            end
        end
    end

endmodule
